// File: rtl/uart_resp_pkg.sv
// Shared constants and state type for the UART command responder.
// Holds the frame delimiter, the request and response codes, the error
// codes carried in error responses, and the parser/transmit state enum.
package uart_resp_pkg;

  localparam logic [7:0] SOF      = 8'hA5;

  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;

  localparam logic [7:0] RSP_WR   = 8'h81;
  localparam logic [7:0] RSP_RD   = 8'h82;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  localparam logic [7:0] ERR_CHK  = 8'h01;
  localparam logic [7:0] ERR_CMD  = 8'h02;
  localparam logic [7:0] ERR_ADDR = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CMD,
    S_GET_ADDR,
    S_GET_DATA,
    S_GET_CHK,
    S_EXEC,
    S_TX_LOAD,
    S_TX_WAIT
  } state_e;

endpackage

// File: rtl/uart_resp_regfile.sv
// Register file for the UART command responder.
// NUM_REGS x 8-bit storage, synchronous write, asynchronous read,
// synchronous active-high reset to zero.
// Ports:
//   clock, reset         : system clock, sync active-high reset
//   wr_en/wr_addr/wr_data: write strobe, address, data
//   rd_addr/rd_data      : combinational read port (0x00 when out of range)
module uart_resp_regfile #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0] mem_q [NUM_REGS];
  logic [7:0] mem_d [NUM_REGS];
  logic       wr_in_range;
  logic       rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < 9'(NUM_REGS));
  assign rd_in_range = ({1'b0, rd_addr} < 9'(NUM_REGS));

  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_in_range) begin
      mem_d[wr_addr[AW-1:0]] = wr_data;
    end
  end

  assign rd_data = rd_in_range ? mem_q[rd_addr[AW-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Far-end command responder for the UART link.
// Parses framed requests (A5 CMD ADDR [DATA] CHK) from the UART receiver,
// executes reads/writes against an internal register file, and returns a
// 5-byte framed response (A5 CODE B2 B3 CHK) through the UART transmitter.
// Ports:
//   clock, reset        : system clock, sync active-high reset
//   rx_data, rx_done    : received byte and its one-cycle valid pulse
//   tx_data, tx_start   : byte to send (held until tx_done) and launch pulse
//   tx_done             : transmitter finished the current byte
//   reg_wr_en/addr/data : strobe and payload of an executed write
//   busy                : frame in progress or response still transmitting
//   rx_overrun          : sticky, byte arrived while responding
// Build option: define UART_RESP_TIMEOUT_EN to discard partial frames after
// TIMEOUT_CYCLES cycles without a received byte.
module uart_cmd_responder
  import uart_resp_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy,
  output logic       rx_overrun
);

`ifdef UART_RESP_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  rsp_q [5];
  logic [7:0]  rsp_d [5];
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ovr_q, ovr_d;
  logic [31:0] tmo_q, tmo_d;

  logic        wr_fire;
  logic        addr_ok;
  logic [7:0]  rd_val;
  logic [7:0]  rsp_code, rsp_b2, rsp_b3;

  uart_resp_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_addr (addr_q),
    .wr_data (data_q),
    .rd_addr (addr_q),
    .rd_data (rd_val)
  );

  assign addr_ok = ({1'b0, addr_q} < 9'(NUM_REGS));

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    chk_d     = chk_q;
    rsp_d     = rsp_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    ovr_d     = ovr_q;
    tmo_d     = '0;
    wr_fire   = 1'b0;
    rsp_code  = RSP_ERR;
    rsp_b2    = '0;
    rsp_b3    = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_done && rx_data == SOF) state_d = S_GET_CMD;
      end
      S_GET_CMD: begin
        if (rx_done) begin
          cmd_d   = rx_data;
          chk_d   = rx_data;
          state_d = S_GET_ADDR;
        end
      end
      S_GET_ADDR: begin
        if (rx_done) begin
          addr_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          // Unknown commands take the read-length path and are rejected in EXEC.
          state_d = (cmd_q == CMD_WR) ? S_GET_DATA : S_GET_CHK;
        end
      end
      S_GET_DATA: begin
        if (rx_done) begin
          data_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_GET_CHK;
        end
      end
      S_GET_CHK: begin
        if (rx_done) begin
          // Folding CHK into the running XOR leaves zero for a good frame.
          chk_d   = chk_q ^ rx_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (chk_q != '0) begin
          rsp_b2 = ERR_CHK;
        end else if (cmd_q != CMD_WR && cmd_q != CMD_RD) begin
          rsp_b2 = ERR_CMD;
        end else if (!addr_ok) begin
          rsp_b2 = ERR_ADDR;
        end else if (cmd_q == CMD_WR) begin
          wr_fire  = 1'b1;
          rsp_code = RSP_WR;
          rsp_b2   = addr_q;
          rsp_b3   = data_q;
        end else begin
          rsp_code = RSP_RD;
          rsp_b2   = addr_q;
          rsp_b3   = rd_val;
        end
        rsp_d[0]  = SOF;
        rsp_d[1]  = rsp_code;
        rsp_d[2]  = rsp_b2;
        rsp_d[3]  = rsp_b3;
        rsp_d[4]  = rsp_code ^ rsp_b2 ^ rsp_b3;
        idx_d     = '0;
        tx_data_d = SOF;
        state_d   = S_TX_LOAD;
        if (rx_done) ovr_d = 1'b1;
      end
      S_TX_LOAD: begin
        state_d = S_TX_WAIT;
        if (rx_done) ovr_d = 1'b1;
      end
      S_TX_WAIT: begin
        if (rx_done) ovr_d = 1'b1;
        if (tx_done) begin
          if (idx_q == 3'd4) begin
            state_d = S_IDLE;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = rsp_q[idx_q + 3'd1];
            state_d   = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout only runs while a request is being collected.
    if (TMO_EN && !rx_done &&
        (state_q inside {S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK})) begin
      tmo_d = tmo_q + 32'd1;
      if (tmo_d >= 32'(TIMEOUT_CYCLES)) begin
        tmo_d   = '0;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      chk_q     <= '0;
      rsp_q     <= '{default: '0};
      idx_q     <= '0;
      tx_data_q <= '0;
      ovr_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      chk_q     <= chk_d;
      rsp_q     <= rsp_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = (state_q == S_TX_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign rx_overrun  = ovr_q;
  assign reg_wr_en   = wr_fire;
  assign reg_wr_addr = addr_q;
  assign reg_wr_data = data_q;

endmodule
